storage_ctrl_gen2: RTL

Second-generation instruction/data storage controller between the vector core's memory port and on-chip storage. It serves a low address window from a single-port on-chip SRAM with byte-masked writes. It serves everything above that window with an integrated SPI flash read engine (command 0x03, mode 0). A programming mode hands the flash pins to an external programmer and can be both entered and exited at run time.

---
 rtl/storage_ctrl_gen2.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/storage_ctrl_gen2.sv
// storage_ctrl_gen2: routes core memory requests to a single-port SRAM window
// or to a SPI flash read engine (cmd 0x03, mode 0); programming mode hands the
// flash pins to an external programmer.
//
// state    | meaning
// IDLE     | ready for a request or a programming-mode entry
// SRAM_RSP | SRAM access issued last cycle; return its response
// SPI_XFER | flash read command, address and data shifting
// ERR_RSP  | rejected flash-region request; return an error
// PROG     | flash pins passed through to the external programmer
module storage_ctrl_gen2 #(
  parameter int          MEM_W      = 32,
  parameter logic [31:0] SRAM_LIMIT = 32'h0000_2000,
  parameter int          SRAM_AW    = 11,
  parameter int          SPI_DIV    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [MEM_W-1:0]     req_wdata,
  input  logic [MEM_W/8-1:0]   req_be,
  output logic                 rsp_valid,
  output logic [MEM_W-1:0]     rsp_rdata,
  output logic                 rsp_err,
  output logic                 sram_ce,
  output logic                 sram_we,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [MEM_W-1:0]     sram_wdata,
  output logic [MEM_W/8-1:0]   sram_wmask,
  input  logic [MEM_W-1:0]     sram_rdata,
  input  logic                 prog_mode,
  output logic                 prog_active,
  output logic                 flash_cs_n,
  output logic                 flash_sck,
  output logic                 flash_mosi,
  input  logic                 flash_miso,
  input  logic                 prog_cs_n,
  input  logic                 prog_sck,
  input  logic                 prog_mosi,
  output logic                 prog_miso
);

  localparam int BW   = MEM_W / 8;
  localparam int LSB  = $clog2(BW);
  localparam int N    = 32 + MEM_W;
  localparam int PH_W = $clog2(2 * SPI_DIV);
  localparam int BC_W = $clog2(N);
  localparam logic [PH_W-1:0] PH_TOP  = PH_W'(2 * SPI_DIV - 1);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(SPI_DIV);
  localparam logic [BC_W-1:0] BIT_TOP = BC_W'(N - 1);

  typedef enum logic [2:0] {IDLE, SRAM_RSP, SPI_XFER, ERR_RSP, PROG} state_t;

  state_t            state_q, state_d;
  logic              accept, in_sram, flash_ok, spi_last;
  logic [31:0]       addr_al, off;
  logic [N-1:0]      tx_init, tx_q;
  logic [MEM_W-1:0]  rx_q, rx_swap, rdata_q;
  logic [PH_W-1:0]   ph_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic              cs_n_q, sck_q, done_q, wr_q;

  // Request decode: window select, flash offset (word aligned) and range check.
  always_comb begin
    addr_al  = req_addr & ~32'(BW - 1);
    off      = addr_al - SRAM_LIMIT;
    in_sram  = (req_addr < SRAM_LIMIT);
    flash_ok = !req_we && (off[31:24] == 8'h00);
    tx_init  = {8'h03, off[23:0], {MEM_W{1'b0}}};
    req_ready = (state_q == IDLE) && !prog_mode && !rst;
    accept    = req_valid && req_ready;
    spi_last  = (ph_cnt == '0) && (bit_cnt == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; programming mode wins over a pending request in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (prog_mode)     state_d = PROG;
        else if (req_valid) begin
          if (in_sram)       state_d = SRAM_RSP;
          else if (flash_ok) state_d = SPI_XFER;
          else               state_d = ERR_RSP;
        end
      end
      SRAM_RSP, ERR_RSP: state_d = IDLE;
      SPI_XFER: if (spi_last) state_d = IDLE;
      PROG:     if (!prog_mode) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // SPI engine: per bit, SCK low for SPI_DIV clocks then high for SPI_DIV;
  // MISO is captured on the edge that raises SCK.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) wr_q <= req_we;
      if (accept && !in_sram && flash_ok) begin
        tx_q    <= tx_init;
        cs_n_q  <= 1'b0;
        sck_q   <= 1'b0;
        ph_cnt  <= PH_TOP;
        bit_cnt <= BIT_TOP;
      end else if (state_q == SPI_XFER) begin
        if (ph_cnt == PH_HI) begin
          sck_q <= 1'b1;
          rx_q  <= {rx_q[MEM_W-2:0], flash_miso};
        end
        if (ph_cnt != '0) begin
          ph_cnt <= ph_cnt - 1'b1;
        end else if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
          ph_cnt  <= PH_TOP;
          sck_q   <= 1'b0;
          tx_q    <= {tx_q[N-2:0], 1'b0};
        end else begin
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          tx_q    <= '0;
          done_q  <= 1'b1;
          rdata_q <= rx_swap;
        end
      end
    end
  end

  // Received bytes arrive first-byte-first; place the first byte at bits [7:0].
  always_comb begin
    rx_swap = '0;
    for (int i = 0; i < BW; i++) rx_swap[8*i +: 8] = rx_q[MEM_W-8-8*i +: 8];
  end

  // SRAM port is driven combinationally in the accept cycle only.
  always_comb begin
    sram_ce    = accept && in_sram;
    sram_we    = sram_ce && req_we;
    sram_addr  = sram_ce ? req_addr[LSB +: SRAM_AW] : '0;
    sram_wdata = sram_ce ? req_wdata : '0;
    sram_wmask = sram_ce ? req_be : '0;
  end

  // Response and flash pin muxing.
  always_comb begin
    rsp_valid = (state_q == SRAM_RSP) || (state_q == ERR_RSP) || done_q;
    rsp_err   = (state_q == ERR_RSP);
    rsp_rdata = '0;
    if (state_q == SRAM_RSP && !wr_q) rsp_rdata = sram_rdata;
    else if (done_q)                  rsp_rdata = rdata_q;
    prog_active = (state_q == PROG);
    flash_cs_n  = prog_active ? prog_cs_n : cs_n_q;
    flash_sck   = prog_active ? prog_sck  : sck_q;
    flash_mosi  = prog_active ? prog_mosi : tx_q[N-1];
    prog_miso   = prog_active ? flash_miso : 1'b0;
  end

endmodule
